// File: rtl/unit_server_pkg.sv
// Shared types for the unit_server responder: bus word, request encoding,
// memory access sizes, FSM states and the ALU opcode set.
package unit_server_pkg;

  typedef logic [31:0] word_t;

  // Request operands: [0] ctrl, [1] operand/address, [2] operand/store data.
  typedef logic [2:0][31:0] unit_in_t;

  typedef enum logic [1:0] {
    UNIT_NONE = 2'd0,
    UNIT_ALU  = 2'd1,
    UNIT_MEM  = 2'd2
  } unit_sel_t;

  typedef enum logic [1:0] {
    MEM_SIZE_BYTE = 2'd0,
    MEM_SIZE_HALF = 2'd1,
    MEM_SIZE_WORD = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } unit_srv_state_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLL = 3'd5,
    ALU_SRL = 3'd6,
    ALU_SLT = 3'd7
  } alu_op_t;

  // MEM ctrl word: bit0 = write, bits[2:1] = size.
  localparam word_t MEM_CTRL_READ_BYTE  = 32'h0000_0000;
  localparam word_t MEM_CTRL_WRITE_BYTE = 32'h0000_0001;
  localparam word_t MEM_CTRL_READ_HALF  = 32'h0000_0002;
  localparam word_t MEM_CTRL_WRITE_HALF = 32'h0000_0003;
  localparam word_t MEM_CTRL_READ_WORD  = 32'h0000_0004;
  localparam word_t MEM_CTRL_WRITE_WORD = 32'h0000_0005;

  // Size code 3 has no meaning of its own and behaves as a full word.
  function automatic mem_size_t ctrl_size(input logic [1:0] code);
    return (code == 2'd3) ? MEM_SIZE_WORD : mem_size_t'(code);
  endfunction

endpackage

// File: rtl/alu.sv
// Single-cycle combinational integer ALU used for UNIT_ALU requests.
module alu
  import unit_server_pkg::*;
(
  input  alu_op_t op,
  input  word_t   a,
  input  word_t   b,
  output word_t   y
);

  always_comb begin
    y = '0;
    case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_XOR: y = a ^ b;
      ALU_SLL: y = a << b[4:0];
      ALU_SRL: y = a >> b[4:0];
      ALU_SLT: y = {31'd0, $signed(a) < $signed(b)};
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/mem_lane.sv
// Byte-lane steering for a 32-bit word-addressed bus: byte enables, store
// replication, load right-justification and alignment check.
module mem_lane
  import unit_server_pkg::*;
(
  input  mem_size_t   size,
  input  logic [1:0]  addr_lo,
  input  word_t       store_data,
  input  word_t       load_data,
  output logic [3:0]  be,
  output word_t       wdata,
  output word_t       rdata,
  output logic        misaligned
);

  word_t shifted;

  always_comb begin
    shifted    = load_data >> {addr_lo, 3'b000};
    be         = 4'hF;
    wdata      = store_data;
    rdata      = shifted;
    misaligned = 1'b0;
    case (size)
      MEM_SIZE_BYTE: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
        rdata = {24'd0, shifted[7:0]};
      end
      MEM_SIZE_HALF: begin
        be         = 4'b0011 << addr_lo;
        wdata      = {2{store_data[15:0]}};
        rdata      = {16'd0, shifted[15:0]};
        misaligned = addr_lo[0];
      end
      default: misaligned = (addr_lo != 2'b00);
    endcase
  end

endmodule

// File: rtl/unit_server.sv
// Responder for the thread's unit handshake: NONE/ALU answer combinationally
// in IDLE, MEM runs IDLE->REQ->RESP->DONE against a single-outstanding bus.
module unit_server
  import unit_server_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  unit_sel_t       unit_sel,
  input  unit_in_t        unit_in,
  output logic            unit_ready,
  output word_t           unit_out,
  output logic            unit_fault,
  output logic            mem_req,
  output logic            mem_we,
  output word_t           mem_addr,
  output logic [3:0]      mem_be,
  output word_t           mem_wdata,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  word_t           mem_rdata,
  output unit_srv_state_t state
);

  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES) - 32'd1;

  unit_srv_state_t next_state;
  mem_size_t       size_q;
  mem_size_t       lane_size;
  logic [1:0]      addr_lo_q;
  logic [1:0]      lane_addr_lo;
  logic            fault_q;
  word_t           result_q;
  logic [31:0]     cnt;
  logic            timeout_hit;
  logic            abort;
  logic            misaligned;
  logic [3:0]      lane_be;
  word_t           lane_wdata;
  word_t           lane_rdata;
  word_t           alu_y;
  logic            unused_ctrl;

  assign unused_ctrl = ^unit_in[0][31:3];

  alu u_alu (
    .op (alu_op_t'(unit_in[0][2:0])),
    .a  (unit_in[1]),
    .b  (unit_in[2]),
    .y  (alu_y)
  );

  // In IDLE the lane logic sees the live request; afterwards the latched copy.
  assign lane_size    = (state == ST_IDLE) ? ctrl_size(unit_in[0][2:1]) : size_q;
  assign lane_addr_lo = (state == ST_IDLE) ? unit_in[1][1:0] : addr_lo_q;

  mem_lane u_mem_lane (
    .size       (lane_size),
    .addr_lo    (lane_addr_lo),
    .store_data (unit_in[2]),
    .load_data  (mem_rdata),
    .be         (lane_be),
    .wdata      (lane_wdata),
    .rdata      (lane_rdata),
    .misaligned (misaligned)
  );

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == TIMEOUT_LAST);
  assign abort = timeout_hit &&
                 (((state == ST_REQ) && !mem_gnt) || ((state == ST_RESP) && !mem_rvalid));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (unit_sel == UNIT_MEM) next_state = misaligned ? ST_DONE : ST_REQ;
      end
      ST_REQ: begin
        if (mem_gnt)    next_state = mem_we ? ST_DONE : ST_RESP;
        else if (abort) next_state = ST_DONE;
      end
      ST_RESP: begin
        if (mem_rvalid || abort) next_state = ST_DONE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    unit_ready = 1'b0;
    unit_out   = '0;
    unit_fault = 1'b0;
    case (state)
      ST_IDLE: begin
        case (unit_sel)
          UNIT_NONE: unit_ready = 1'b1;
          UNIT_ALU: begin
            unit_ready = 1'b1;
            unit_out   = alu_y;
          end
          default: unit_ready = 1'b0;
        endcase
      end
      ST_DONE: begin
        unit_ready = 1'b1;
        unit_out   = result_q;
        unit_fault = fault_q;
      end
      default: unit_ready = 1'b0;
    endcase
  end

  // Bus outputs and access latches; mem_req follows the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      size_q    <= MEM_SIZE_BYTE;
      addr_lo_q <= '0;
      fault_q   <= 1'b0;
      result_q  <= '0;
      cnt       <= '0;
    end else begin
      mem_req <= (next_state == ST_REQ);
      if (next_state != state)                     cnt <= '0;
      else if (state == ST_REQ || state == ST_RESP) cnt <= cnt + 32'd1;
      case (state)
        ST_IDLE: begin
          if (unit_sel == UNIT_MEM) begin
            size_q    <= lane_size;
            addr_lo_q <= lane_addr_lo;
            fault_q   <= misaligned;
            result_q  <= '0;
            mem_we    <= unit_in[0][0];
            mem_addr  <= {unit_in[1][31:2], 2'b00};
            mem_be    <= lane_be;
            mem_wdata <= lane_wdata;
          end
        end
        ST_RESP: begin
          if (mem_rvalid) result_q <= lane_rdata;
        end
        default: ;
      endcase
      if (abort) fault_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_unit_server.sv
// Directed bench for unit_server: ALU/NONE replies, aligned reads and writes,
// misalignment, timeout (second instance with a short limit) and mid-access reset.
module tb_unit_server;
  import unit_server_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  unit_sel_t       sel, sel2;
  unit_in_t        uin;
  logic            gnt, rvalid;
  word_t           rdata;

  logic            ready, fault, req, we;
  word_t           out, addr, wdata;
  logic [3:0]      be;
  unit_srv_state_t st;

  logic            ready2, fault2, req2, we2;
  word_t           out2, addr2, wdata2;
  logic [3:0]      be2;
  unit_srv_state_t st2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  unit_server u_dut (
    .clk(clk), .rst(rst), .unit_sel(sel), .unit_in(uin),
    .unit_ready(ready), .unit_out(out), .unit_fault(fault),
    .mem_req(req), .mem_we(we), .mem_addr(addr), .mem_be(be), .mem_wdata(wdata),
    .mem_gnt(gnt), .mem_rvalid(rvalid), .mem_rdata(rdata), .state(st)
  );

  unit_server #(.TIMEOUT_CYCLES(3)) u_to (
    .clk(clk), .rst(rst), .unit_sel(sel2), .unit_in(uin),
    .unit_ready(ready2), .unit_out(out2), .unit_fault(fault2),
    .mem_req(req2), .mem_we(we2), .mem_addr(addr2), .mem_be(be2), .mem_wdata(wdata2),
    .mem_gnt(gnt), .mem_rvalid(rvalid), .mem_rdata(rdata), .state(st2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic present(input unit_sel_t s, input word_t c, input word_t a, input word_t d);
    sel    = s;
    uin[0] = c;
    uin[1] = a;
    uin[2] = d;
    #1;
  endtask

  initial begin
    rst = 1'b1; sel = UNIT_NONE; sel2 = UNIT_NONE; uin = '0;
    gnt = 1'b0; rvalid = 1'b0; rdata = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_addr", addr, 32'd0);
    chk("rst_be", 32'(be), 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_state", 32'(st), 32'(ST_IDLE));
    chk("rst_none_ready", 32'(ready), 32'd1);
    chk("rst_none_out", out, 32'd0);
    rst = 1'b0;
    tick();

    // ALU and NONE answer in the same cycle
    present(UNIT_ALU, 32'(ALU_ADD), 32'd5, 32'd7);
    chk("alu_add_ready", 32'(ready), 32'd1);
    chk("alu_add_out", out, 32'd12);
    present(UNIT_ALU, 32'(ALU_SUB), 32'd5, 32'd7);
    chk("alu_sub_out", out, 32'hFFFF_FFFE);
    present(UNIT_NONE, 32'd0, 32'h1234, 32'h5678);
    chk("none_ready", 32'(ready), 32'd1);
    chk("none_out", out, 32'd0);
    tick();

    // Read byte at 0x103, immediate grant, rvalid next cycle
    present(UNIT_MEM, MEM_CTRL_READ_BYTE, 32'h103, 32'd0);
    chk("rdb_c0_ready", 32'(ready), 32'd0);
    chk("rdb_c0_req", 32'(req), 32'd0);
    tick();
    chk("rdb_c1_req", 32'(req), 32'd1);
    chk("rdb_addr", addr, 32'h100);
    chk("rdb_be", 32'(be), 32'h8);
    chk("rdb_we", 32'(we), 32'd0);
    chk("rdb_c1_ready", 32'(ready), 32'd0);
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    chk("rdb_c2_req", 32'(req), 32'd0);
    chk("rdb_c2_ready", 32'(ready), 32'd0);
    rvalid = 1'b1; rdata = 32'hA1B2_C3D4;
    tick();
    rvalid = 1'b0;
    chk("rdb_c3_ready", 32'(ready), 32'd1);
    chk("rdb_out", out, 32'h0000_00A1);
    chk("rdb_fault", 32'(fault), 32'd0);
    sel = UNIT_NONE;
    tick();

    // Read half at 0x102; rvalid in the grant cycle must be ignored
    present(UNIT_MEM, MEM_CTRL_READ_HALF, 32'h102, 32'd0);
    tick();
    chk("rdh_be", 32'(be), 32'hC);
    gnt = 1'b1; rvalid = 1'b1; rdata = 32'hFFFF_FFFF;
    tick();
    gnt = 1'b0; rvalid = 1'b0;
    chk("rdh_resp_wait", 32'(st), 32'(ST_RESP));
    chk("rdh_no_ready", 32'(ready), 32'd0);
    rvalid = 1'b1; rdata = 32'hA1B2_C3D4;
    tick();
    rvalid = 1'b0;
    chk("rdh_ready", 32'(ready), 32'd1);
    chk("rdh_out", out, 32'h0000_A1B2);
    sel = UNIT_NONE;
    tick();

    // Write half 0xBEEF at 0x202 with grant in the fourth REQ cycle
    present(UNIT_MEM, MEM_CTRL_WRITE_HALF, 32'h202, 32'h1234_BEEF);
    tick();
    chk("wrh_addr", addr, 32'h200);
    chk("wrh_be", 32'(be), 32'hC);
    chk("wrh_wdata", wdata, 32'hBEEF_BEEF);
    chk("wrh_we", 32'(we), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("wrh_req_c%0d", i + 1), 32'(req), 32'd1);
      chk($sformatf("wrh_wait_c%0d", i + 1), 32'(ready), 32'd0);
      if (i == 3) gnt = 1'b1;
      else        tick();
    end
    tick();
    gnt = 1'b0;
    chk("wrh_ready", 32'(ready), 32'd1);
    chk("wrh_out", out, 32'd0);
    chk("wrh_req_drop", 32'(req), 32'd0);

    // Back-to-back: write word, then read byte at 0x301 presented in DONE
    sel = UNIT_NONE;
    tick();
    present(UNIT_MEM, MEM_CTRL_WRITE_WORD, 32'h300, 32'hDEAD_BEEF);
    tick();
    chk("wrw_be", 32'(be), 32'hF);
    chk("wrw_wdata", wdata, 32'hDEAD_BEEF);
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    chk("wrw_ready_c2", 32'(ready), 32'd1);
    present(UNIT_MEM, MEM_CTRL_READ_BYTE, 32'h301, 32'd0);
    tick();
    chk("b2b_idle_gap", 32'(req), 32'd0);
    tick();
    chk("b2b_req", 32'(req), 32'd1);
    chk("b2b_be", 32'(be), 32'h2);
    gnt = 1'b1;
    tick();
    gnt = 1'b0; rvalid = 1'b1; rdata = 32'hA1B2_C3D4;
    tick();
    rvalid = 1'b0;
    chk("b2b_out", out, 32'h0000_00C3);
    sel = UNIT_NONE;
    tick();

    // Misaligned word read at 0x6: no bus access, fault one cycle later
    present(UNIT_MEM, MEM_CTRL_READ_WORD, 32'h6, 32'd0);
    chk("mis_c0_ready", 32'(ready), 32'd0);
    tick();
    chk("mis_req", 32'(req), 32'd0);
    chk("mis_ready", 32'(ready), 32'd1);
    chk("mis_fault", 32'(fault), 32'd1);
    chk("mis_out", out, 32'd0);
    sel = UNIT_NONE;
    tick();
    chk("mis_fault_clear", 32'(fault), 32'd0);

    // Timeout instance: grant never comes
    sel2 = UNIT_MEM; uin[0] = MEM_CTRL_READ_WORD; uin[1] = 32'h40; uin[2] = 32'd0;
    #1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("to_req_c%0d", i + 1), 32'(req2), 32'd1);
      chk($sformatf("to_wait_c%0d", i + 1), 32'(ready2), 32'd0);
    end
    tick();
    chk("to_req_drop", 32'(req2), 32'd0);
    chk("to_ready", 32'(ready2), 32'd1);
    chk("to_fault", 32'(fault2), 32'd1);
    chk("to_out", out2, 32'd0);
    sel2 = UNIT_NONE;
    tick();
    sel2 = UNIT_MEM; uin[1] = 32'h44;
    #1;
    tick();
    chk("to_next_req", 32'(req2), 32'd1);
    gnt = 1'b1;
    tick();
    gnt = 1'b0; rvalid = 1'b1; rdata = 32'h1122_3344;
    tick();
    rvalid = 1'b0;
    chk("to_next_ready", 32'(ready2), 32'd1);
    chk("to_next_out", out2, 32'h1122_3344);
    chk("to_next_fault", 32'(fault2), 32'd0);
    sel2 = UNIT_NONE;
    tick();

    // Reset while waiting in RESP, then a stray rvalid
    present(UNIT_MEM, MEM_CTRL_READ_WORD, 32'h10, 32'd0);
    tick();
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    chk("rr_in_resp", 32'(st), 32'(ST_RESP));
    rst = 1'b1;
    #1;
    chk("rr_req", 32'(req), 32'd0);
    chk("rr_state", 32'(st), 32'(ST_IDLE));
    chk("rr_ready", 32'(ready), 32'd0);
    chk("rr_fault", 32'(fault), 32'd0);
    rvalid = 1'b1; rdata = 32'h5555_5555;
    tick();
    chk("rr_stray_state", 32'(st), 32'(ST_IDLE));
    chk("rr_stray_ready", 32'(ready), 32'd0);
    chk("rr_stray_out", out, 32'd0);
    sel = UNIT_NONE;
    rst = 1'b0;
    tick();
    rvalid = 1'b0;
    chk("rr_after_state", 32'(st), 32'(ST_IDLE));
    chk("rr_after_req", 32'(req), 32'd0);
    chk("rr_after_out", out, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/unit_server.md
# unit_server

Responder side of the thread's unit handshake: accepts `unit_sel`/`unit_in` from one `thread`, answers with `unit_ready`/`unit_out`. NONE and ALU requests complete combinationally; MEM requests run a registered FSM against a single-outstanding word-addressed memory bus. The block does lane alignment, byte enables, right-justification and timeout. One `unit_server` sits beside each `thread` instance, between the core and the bus interconnect.

## Interface
- `TIMEOUT_CYCLES`, default 255: bus cycles allowed per phase before the access is aborted; 0 disables the timeout.
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous reset, active high.
- `unit_sel`  in  unit_sel_t  NONE / ALU / MEM.
- `unit_in`  in  unit_in_t  [0] ctrl, [1] operand/address, [2] operand/store data.
- `unit_ready`  out  1  request complete this cycle.
- `unit_out`  out  word_t  result; valid only while `unit_ready`=1.
- `unit_fault`  out  1  pulses with `unit_ready` on a misaligned or timed-out MEM access.
- `mem_req`  out  1  bus request; held until `mem_gnt`.
- `mem_we`  out  1  write access.
- `mem_addr`  out  word_t  address with bits [1:0] forced to 0.
- `mem_be`  out  4  byte enables.
- `mem_wdata`  out  word_t  lane-replicated store data.
- `mem_gnt`  in  1  request accepted this cycle.
- `mem_rvalid`  in  1  read data valid; arrives at least one cycle after `mem_gnt`.
- `mem_rdata`  in  word_t  read data.

## Operation
- MEM ctrl word: bit0 = write, bits[2:1] = size (0 byte, 1 half, 2 word). Size 3 is treated as word.
- NONE: `unit_ready`=1 and `unit_out`=0 combinationally.
- ALU: `unit_ready`=1 and `unit_out`=alu(`unit_in`) combinationally. Both NONE and ALU answer only in IDLE.
- The FSM states are IDLE, REQ, RESP and DONE.
- IDLE, `unit_sel`=MEM:
  - Latch ctrl, address and data.
  - Misaligned access (half with addr[0]=1, or word with addr[1:0]≠0): go to DONE with fault set. No bus access is made.
  - Otherwise go to REQ.
- REQ:
  - Drive `mem_req`=1 with registered addr, be, we and wdata.
  - On `mem_gnt`: a write goes to DONE; a read goes to RESP.
- RESP: on `mem_rvalid`, capture `mem_rdata` shifted right by 8×addr[1:0], masked to size and zero-extended, then go to DONE. The thread performs sign extension.
- DONE: `unit_ready`=1, `unit_out`=captured data (0 for writes and faults), `unit_fault`=fault flag, then return to IDLE.
- Byte enables: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<addr[1:0]; word = 4'hF.
- Store data: byte = {4{d[7:0]}}, half = {2{d[15:0]}}, word = d.
- Timeout: the counter resets on entry to REQ and to RESP. When it reaches `TIMEOUT_CYCLES` in either state, drop `mem_req`, set fault, go to DONE.
- Requester rule: `unit_sel`/`unit_in` are held stable until `unit_ready`. The block samples them only in IDLE; later changes are ignored.

## Timing
- Reset value of every output is 0 (combinational NONE response excepted). FSM state = IDLE, latches and counter cleared.
- Bus outputs are registered; `mem_req` rises the cycle after IDLE samples MEM.
- Read with `mem_gnt` in the first REQ cycle and `mem_rvalid` one cycle later: `unit_ready` three cycles after the request is presented.
- Write with immediate `mem_gnt`: `unit_ready` two cycles after the request is presented.
- Misaligned access: `unit_ready` one cycle after the request is presented.
- Back-to-back MEM: the DONE cycle returns to IDLE, so the next request starts the following cycle. One idle cycle separates bus accesses.
- `mem_rvalid` arriving outside RESP is ignored, including the same cycle as `mem_gnt`.
- Reset mid-access drops `mem_req` immediately. Any later `mem_rvalid` is ignored.

## Structure
- `types.sv` holds:
  - MEM_CTRL_* constants (READ/WRITE × BYTE/HALF/WORD);
  - `MEM_SIZE_*` enum;
  - `unit_srv_state_t` enum.
- Instantiates the existing `alu`.
- One new combinational sub-module, `mem_lane`, takes size, addr[1:0], store data and read data. It produces `be`, `wdata`, aligned read data and the `misaligned` flag.

## Test plan
- ALU request (ADD, 5, 7) in IDLE → same-cycle `unit_ready`=1, `unit_out`=12. NONE → `unit_ready`=1, `unit_out`=0.
- Read byte at 0x103, `mem_rdata`=0xA1B2C3D4, immediate gnt, rvalid next cycle → `mem_addr`=0x100, `mem_be`=4'b1000; `unit_out`=0x000000A1, ready at cycle 3.
- Write half 0xBEEF at 0x202, gnt delayed 4 cycles → `mem_req` held 4 cycles, `mem_be`=4'b1100, `mem_wdata`=0xBEEFBEEF; ready the cycle after gnt.
- Read word at 0x6 → no `mem_req`; `unit_ready` and `unit_fault` at cycle 1, `unit_out`=0.
- `TIMEOUT_CYCLES`=3, gnt never asserted → `mem_req` high 3 cycles then low; ready with fault next cycle. Next request completes normally.
- `rst` asserted in RESP, then stray `mem_rvalid` → outputs 0, state IDLE, no `unit_ready`.
